// File: rtl/mh_4s2_seq.sv
// mh_4s2_seq
// Sequential 4-to-2 priority encoder with sticky request buffering.
// Requests on Y3..Y0 are captured every edge into PEND and issued one at a
// time, highest priority first, as a 2-bit code over a VALID/READY handshake.
//
// Parameters:
//   PRIO_HIGH  1: Y3 highest priority, Y0 lowest; 0: Y0 highest, Y3 lowest
//
// Ports:
//   CLK      in   system clock, rising edge
//   RST_N    in   asynchronous active-low reset
//   Y0..Y3   in   request lines for codes 00..11 (level-sampled)
//   READY    in   consumer accepts {I1,I0} when high together with VALID
//   ERR_CLR  in   synchronous clear of ERR
//   I1, I0   out  issued code (MSB, LSB)
//   VALID    out  {I1,I0} holds an unconsumed code
//   PEND     out  pending-request register, bit n = Yn
//   ERR      out  sticky non-one-hot flag
//
// Build option:
//   MH_4S2_ONEHOT_CHK_EN  defined: one-hot checker drives ERR.
//                         undefined: ERR tied low, ERR_CLR ignored.

module mh_4s2_seq #(
    parameter int PRIO_HIGH = 1
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       Y0,
    input  logic       Y1,
    input  logic       Y2,
    input  logic       Y3,
    input  logic       READY,
    input  logic       ERR_CLR,
    output logic       I1,
    output logic       I0,
    output logic       VALID,
    output logic [3:0] PEND,
    output logic       ERR
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t     state;
    logic [3:0] req;
    logic [3:0] grant;
    logic [1:0] grant_idx;
    logic       load;

    always_comb begin
        req  = {Y3, Y2, Y1, Y0};
        // The output slot is free when empty or being accepted this edge.
        load = ((state == IDLE) || READY) && (PEND != '0);

        grant_idx = '0;
        if (PRIO_HIGH != 0) begin
            if (PEND[3])      grant_idx = 2'd3;
            else if (PEND[2]) grant_idx = 2'd2;
            else if (PEND[1]) grant_idx = 2'd1;
            else              grant_idx = 2'd0;
        end else begin
            if (PEND[0])      grant_idx = 2'd0;
            else if (PEND[1]) grant_idx = 2'd1;
            else if (PEND[2]) grant_idx = 2'd2;
            else              grant_idx = 2'd3;
        end

        grant = load ? (4'b0001 << grant_idx) : '0;
    end

    assign VALID = (state == HOLD);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
            PEND  <= '0;
            I1    <= 1'b0;
            I0    <= 1'b0;
        end else begin
            // New requests are OR-ed in after the grant is removed, so a
            // request arriving on its own grant edge stays pending.
            PEND <= (PEND & ~grant) | req;
            case (state)
                IDLE: begin
                    if (load) begin
                        state    <= HOLD;
                        {I1, I0} <= grant_idx;
                    end
                end
                HOLD: begin
                    if (READY) begin
                        if (load) begin
                            {I1, I0} <= grant_idx;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MH_4S2_ONEHOT_CHK_EN
    logic multi_req;

    // More than one bit set: clearing the lowest set bit leaves something.
    assign multi_req = ((req & (req - 4'd1)) != '0);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ERR <= 1'b0;
        end else if (multi_req) begin
            ERR <= 1'b1;
        end else if (ERR_CLR) begin
            ERR <= 1'b0;
        end
    end
`else
    logic unused_err_clr;

    assign unused_err_clr = ERR_CLR;
    assign ERR            = 1'b0;
`endif

endmodule

// File: tb/tb_mh_4s2_seq.sv
// Testbench for mh_4s2_seq: two instances (PRIO_HIGH=1 and PRIO_HIGH=0)
// share stimulus and are compared against a behavioural model each cycle,
// plus directed checks against fixed expected values.

module tb_mh_4s2_seq;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic [3:0] y_in;
    logic       ready;
    logic       err_clr;

    logic       i1_a, i0_a, valid_a, err_a;
    logic       i1_b, i0_b, valid_b, err_b;
    logic [3:0] pend_a, pend_b;

    int n_chk  = 0;
    int n_fail = 0;

    // Model state, index 0 = PRIO_HIGH=1, index 1 = PRIO_HIGH=0
    logic [3:0] m_pend  [2];
    logic       m_valid [2];
    logic [1:0] m_code  [2];
    logic       m_err;

    logic [7:0] obs [2];

    always #5 CLK = ~CLK;

    mh_4s2_seq #(.PRIO_HIGH(1)) dut_hi (
        .CLK(CLK), .RST_N(RST_N),
        .Y0(y_in[0]), .Y1(y_in[1]), .Y2(y_in[2]), .Y3(y_in[3]),
        .READY(ready), .ERR_CLR(err_clr),
        .I1(i1_a), .I0(i0_a), .VALID(valid_a), .PEND(pend_a), .ERR(err_a)
    );

    mh_4s2_seq #(.PRIO_HIGH(0)) dut_lo (
        .CLK(CLK), .RST_N(RST_N),
        .Y0(y_in[0]), .Y1(y_in[1]), .Y2(y_in[2]), .Y3(y_in[3]),
        .READY(ready), .ERR_CLR(err_clr),
        .I1(i1_b), .I0(i0_b), .VALID(valid_b), .PEND(pend_b), .ERR(err_b)
    );

    assign obs[0] = {valid_a, i1_a, i0_a, pend_a, err_a};
    assign obs[1] = {valid_b, i1_b, i0_b, pend_b, err_b};

    function automatic logic [7:0] exp_of(input int p);
        return {m_valid[p], m_code[p], m_pend[p], m_err};
    endfunction

    // Index of the request that wins: top set bit (p=0) or bottom set bit (p=1)
    function automatic logic [1:0] pick(input int p, input logic [3:0] pend);
        int v;
        int low;
        v = int'(pend);
        if (p == 0) return 2'($clog2(v + 1) - 1);
        low = v & ((~v) + 1);
        return 2'($clog2(low));
    endfunction

    task automatic model_reset();
        for (int p = 0; p < 2; p++) begin
            m_pend[p]  = 4'b0000;
            m_valid[p] = 1'b0;
            m_code[p]  = 2'b00;
        end
        m_err = 1'b0;
    endtask

    task automatic model_step();
        logic [1:0] idx;
        if (!RST_N) begin
            model_reset();
            return;
        end
        for (int p = 0; p < 2; p++) begin
            if ((!m_valid[p] || ready) && m_pend[p] != 4'b0000) begin
                idx        = pick(p, m_pend[p]);
                m_code[p]  = idx;
                m_valid[p] = 1'b1;
                m_pend[p]  = (m_pend[p] - (4'd1 << idx)) | y_in;
            end else begin
                if (m_valid[p] && ready) m_valid[p] = 1'b0;
                m_pend[p] = m_pend[p] | y_in;
            end
        end
`ifdef MH_4S2_ONEHOT_CHK_EN
        if ($countones(y_in) > 1) m_err = 1'b1;
        else if (err_clr)         m_err = 1'b0;
`endif
    endtask

    // Advance one rising edge, update the model, sample 1 time unit later.
    task automatic tick();
        @(posedge CLK);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        RST_N = 1'b0; y_in = '0; ready = 1'b0; err_clr = 1'b0;
        model_reset();
        #1;
        for (int p = 0; p < 2; p++) begin
            n_chk++;
            if (obs[p] !== 8'h00) begin
                n_fail++;
                $display("FAIL reset_state inst%0d got=%b exp=%b", p, obs[p], 8'h00);
            end
        end
        #1 RST_N = 1'b1;
        tick();
        for (int p = 0; p < 2; p++) begin
            n_chk++;
            if (obs[p] !== exp_of(p)) begin
                n_fail++;
                $display("FAIL reset_release inst%0d got=%b exp=%b", p, obs[p], exp_of(p));
            end
        end
    endtask

    task automatic test_single_request();
        logic [7:0] want [3];
        want[0] = {1'b0, 2'b00, 4'b0100, 1'b0};
        want[1] = {1'b1, 2'b10, 4'b0000, 1'b0};
        want[2] = {1'b0, 2'b10, 4'b0000, 1'b0};
        ready = 1'b1; y_in = 4'b0100;
        for (int k = 0; k < 3; k++) begin
            tick();
            y_in = 4'b0000;
            for (int p = 0; p < 2; p++) begin
                n_chk++;
                if (obs[p] !== want[k] || obs[p] !== exp_of(p)) begin
                    n_fail++;
                    $display("FAIL single_req step%0d inst%0d got=%b exp=%b", k, p, obs[p], want[k]);
                end
            end
        end
    endtask

    task automatic test_priority_burst();
        logic [1:0] seq_hi [4];
        logic [1:0] seq_lo [4];
        seq_hi[0] = 2'd3; seq_hi[1] = 2'd2; seq_hi[2] = 2'd1; seq_hi[3] = 2'd0;
        seq_lo[0] = 2'd0; seq_lo[1] = 2'd1; seq_lo[2] = 2'd2; seq_lo[3] = 2'd3;
        ready = 1'b1; y_in = 4'b1111;
        tick();
        y_in = 4'b0000;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (k < 4) begin
                n_chk++;
                if ({valid_a, i1_a, i0_a} !== {1'b1, seq_hi[k]}) begin
                    n_fail++;
                    $display("FAIL burst_hi slot%0d got=%b exp=%b", k, {valid_a, i1_a, i0_a}, {1'b1, seq_hi[k]});
                end
                n_chk++;
                if ({valid_b, i1_b, i0_b} !== {1'b1, seq_lo[k]}) begin
                    n_fail++;
                    $display("FAIL burst_lo slot%0d got=%b exp=%b", k, {valid_b, i1_b, i0_b}, {1'b1, seq_lo[k]});
                end
            end else begin
                n_chk++;
                if ({valid_a, valid_b} !== 2'b00) begin
                    n_fail++;
                    $display("FAIL burst_end got=%b exp=00", {valid_a, valid_b});
                end
            end
            for (int p = 0; p < 2; p++) begin
                n_chk++;
                if (obs[p] !== exp_of(p)) begin
                    n_fail++;
                    $display("FAIL burst_model slot%0d inst%0d got=%b exp=%b", k, p, obs[p], exp_of(p));
                end
            end
        end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [7:0] hold_v;
        ready = 1'b0; y_in = 4'b0010;
        tick();
        y_in = 4'b0000;
        tick();
        y_in = 4'b1000;
        tick();
        y_in = 4'b0000;
        hold_v = {1'b1, 2'b01, 4'b1000, 1'b0};
        for (int k = 0; k < 3; k++) begin
            for (int p = 0; p < 2; p++) begin
                n_chk++;
                if (obs[p] !== hold_v || obs[p] !== exp_of(p)) begin
                    n_fail++;
                    $display("FAIL backpressure_hold cyc%0d inst%0d got=%b exp=%b", k, p, obs[p], hold_v);
                end
            end
            tick();
        end
        ready = 1'b1;
        tick();
        for (int p = 0; p < 2; p++) begin
            n_chk++;
            if (obs[p] !== {1'b1, 2'b11, 4'b0000, 1'b0} || obs[p] !== exp_of(p)) begin
                n_fail++;
                $display("FAIL backpressure_next inst%0d got=%b exp=%b", p, obs[p], {1'b1, 2'b11, 4'b0000, 1'b0});
            end
        end
        tick();
        n_chk++;
        if ({valid_a, valid_b} !== 2'b00) begin
            n_fail++;
            $display("FAIL backpressure_drain got=%b exp=00", {valid_a, valid_b});
        end
    endtask

    task automatic test_collision();
        ready = 1'b1; y_in = 4'b0001;
        tick();
        for (int k = 0; k < 5; k++) begin
            tick();
            for (int p = 0; p < 2; p++) begin
                n_chk++;
                if (obs[p] !== {1'b1, 2'b00, 4'b0001, 1'b0} || obs[p] !== exp_of(p)) begin
                    n_fail++;
                    $display("FAIL set_clear cyc%0d inst%0d got=%b exp=%b", k, p, obs[p], {1'b1, 2'b00, 4'b0001, 1'b0});
                end
            end
        end
        y_in = 4'b0000;
        tick();
        tick();
    endtask

    task automatic test_checker();
        logic       on;
        logic [3:0] ys  [5];
        logic       clr [5];
        logic       want[5];
`ifdef MH_4S2_ONEHOT_CHK_EN
        on = 1'b1;
`else
        on = 1'b0;
`endif
        ys[0] = 4'b0101; clr[0] = 1'b0; want[0] = on;
        ys[1] = 4'b0000; clr[1] = 1'b0; want[1] = on;
        ys[2] = 4'b0000; clr[2] = 1'b1; want[2] = 1'b0;
        ys[3] = 4'b0011; clr[3] = 1'b1; want[3] = on;
        ys[4] = 4'b0100; clr[4] = 1'b0; want[4] = on;
        ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            y_in = ys[k]; err_clr = clr[k];
            tick();
            n_chk++;
            if (err_a !== want[k] || err_b !== want[k]) begin
                n_fail++;
                $display("FAIL checker step%0d got=%b%b exp=%b", k, err_a, err_b, want[k]);
            end
        end
        y_in = 4'b0000; err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        repeat (6) tick();
    endtask

    task automatic test_mid_reset();
        ready = 1'b0; y_in = 4'b0010;
        tick();
        y_in = 4'b0000;
        tick();
        y_in = 4'b1010;
        tick();
        y_in = 4'b0000;
        n_chk++;
        if ({valid_a, pend_a} !== {1'b1, 4'b1010}) begin
            n_fail++;
            $display("FAIL mid_reset_setup got=%b exp=%b", {valid_a, pend_a}, {1'b1, 4'b1010});
        end
        #1 RST_N = 1'b0;
        model_reset();
        #1;
        for (int p = 0; p < 2; p++) begin
            n_chk++;
            if (obs[p] !== 8'h00) begin
                n_fail++;
                $display("FAIL mid_reset inst%0d got=%b exp=%b", p, obs[p], 8'h00);
            end
        end
        tick();
        n_chk++;
        if ({obs[0], obs[1]} !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_hold got=%b exp=0", {obs[0], obs[1]});
        end
        RST_N = 1'b1;
        tick();
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            case ($urandom_range(0, 3))
                0:       y_in = 4'($urandom_range(0, 15));
                1:       y_in = 4'b0001 << $urandom_range(0, 3);
                default: y_in = 4'b0000;
            endcase
            ready   = ($urandom_range(0, 3) != 0);
            err_clr = ($urandom_range(0, 7) == 0);
            tick();
            for (int p = 0; p < 2; p++) begin
                n_chk++;
                if (obs[p] !== exp_of(p)) begin
                    n_fail++;
                    $display("FAIL random cyc%0d inst%0d got=%b exp=%b", k, p, obs[p], exp_of(p));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_request();
        test_priority_burst();
        test_backpressure();
        test_collision();
        test_checker();
        test_mid_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
